// File: rtl/rv32_dmem_responder.sv
// Word-addressed data memory slave: single-cycle byte-enabled writes and
// reads that stall for WAIT_STATES cycles before presenting registered data.
module rv32_dmem_responder #(
  parameter int unsigned LOG2_WORDS  = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        access_err
);

  localparam int unsigned NUM_WORDS = 1 << LOG2_WORDS;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic                    load_s;
  logic                    err_s;
  logic [31:0]             offset_s;
  logic                    in_range_s;
  logic [LOG2_WORDS-1:0]   idx_s;
  logic [31:0]             old_word_s;
  logic [31:0]             merged_s;
  logic [31:0]             load_data_s;
  logic [31:0]             readdata_r;
  logic                    access_err_r;
  logic [31:0]             mem_r [NUM_WORDS];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  assign offset_s   = address - BASE_ADDR;
  assign in_range_s = (offset_s >> (LOG2_WORDS + 2)) == 32'd0;
  assign idx_s      = offset_s[LOG2_WORDS+1:2];
  assign old_word_s = mem_r[idx_s];

  // Write-first view of the addressed word; also the value stored on a write.
  always_comb begin
    merged_s = old_word_s;
    if (write && in_range_s) begin
      merged_s = byte_merge(old_word_s, writedata, byteenable);
    end else begin
      merged_s = old_word_s;
    end
    load_data_s = in_range_s ? merged_s : 32'd0;
  end

  // Read FSM next-state, wait counter and DATA-entry strobe.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (read) begin
          cnt_s = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0) begin
            state_s = ST_DATA;
            load_s  = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!read) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_s = ST_DATA;
            load_s  = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_DATA: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    err_s = !in_range_s && (write || load_s);
  end

  // FSM, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      readdata_r   <= 32'd0;
      access_err_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      access_err_r <= err_s;
      if (load_s) begin
        readdata_r <= load_data_s;
      end
    end
  end

  // Storage survives reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (write && in_range_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  assign readdata    = readdata_r;
  assign access_err  = access_err_r;
  assign waitrequest = read && (state_r != ST_DATA);

endmodule
